// File: rtl/mmio_timer_led_if.sv
// Core-side memory bus as seen by a memory-mapped peripheral.
// The master drives address, strobes and write data; the slave returns
// registered read data together with a hit flag.
interface mmio_timer_led_if #(
   parameter int AW = 8,
   parameter int DW = 32
);
   logic [AW-1:0] mem_addr;
   logic          mem_read_en;
   logic          mem_write_en;
   logic [DW-1:0] mem_write_val;
   logic [DW-1:0] mem_read_val;
   logic          hit;

   modport master (
      output mem_addr, mem_read_en, mem_write_en, mem_write_val,
      input  mem_read_val, hit
   );

   modport slave (
      input  mem_addr, mem_read_en, mem_write_en, mem_write_val,
      output mem_read_val, hit
   );
endinterface

// File: rtl/mmio_timer_led.sv
// Memory-mapped LED register and free-running compare timer.
// A 4-word window at BASE_ADDR holds LED, CTRL{MF,AR,EN}, COUNT and CMP.
// Read data and hit are registered, so the top level sees the same
// one-cycle latency as RAM and can mux on hit.
module mmio_timer_led #(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_SIZE  = 256,
   parameter int BASE_ADDR = 208
) (
   input  logic                clk,
   input  logic                reset,
   mmio_timer_led_if.slave     bus,
   output logic [3:0]          led,
   output logic                match
);
   localparam int AW = $clog2(MEM_SIZE);
   localparam logic [AW-3:0] BASE_HI = (AW-2)'(BASE_ADDR >> 2);

   localparam logic [1:0] OFF_LED   = 2'd0;
   localparam logic [1:0] OFF_CTRL  = 2'd1;
   localparam logic [1:0] OFF_COUNT = 2'd2;
   localparam logic [1:0] OFF_CMP   = 2'd3;

   logic [3:0]           led_q,   led_d;
   logic                 en_q,    en_d;
   logic                 ar_q,    ar_d;
   logic                 mf_q,    mf_d;
   logic [MEM_WIDTH-1:0] count_q, count_d;
   logic [MEM_WIDTH-1:0] cmp_q,   cmp_d;
   logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
   logic                 hit_q,   hit_d;

   logic                 sel;
   logic [1:0]           offset;
   logic                 wr;
   logic                 rd;
   logic                 cmp_hit;
   logic [MEM_WIDTH-1:0] rd_mux;

   assign sel     = (bus.mem_addr[AW-1:2] == BASE_HI);
   assign offset  = bus.mem_addr[1:0];
   assign wr      = bus.mem_write_en & sel;
   assign rd      = bus.mem_read_en  & sel;
   // Match uses the pre-edge COUNT, even when a bus write replaces it.
   assign cmp_hit = en_q & (count_q == cmp_q);

   // Select the addressed register's current (pre-write) value.
   always_comb begin
      rd_mux = '0;
      unique case (offset)
         OFF_LED:   rd_mux[3:0] = led_q;
         OFF_CTRL:  rd_mux[2:0] = {mf_q, ar_q, en_q};
         OFF_COUNT: rd_mux      = count_q;
         OFF_CMP:   rd_mux      = cmp_q;
         default:   rd_mux      = '0;
      endcase
   end

   // Next-state for registers, timer and read pipeline.
   always_comb begin
      led_d   = led_q;
      en_d    = en_q;
      ar_d    = ar_q;
      mf_d    = mf_q;
      cmp_d   = cmp_q;
      count_d = count_q;
      rdata_d = '0;
      hit_d   = 1'b0;

      if (en_q) begin
         if (cmp_hit && ar_q) count_d = '0;
         else                 count_d = count_q + 1'b1;
      end

      if (wr) begin
         unique case (offset)
            OFF_LED: led_d = bus.mem_write_val[3:0];
            OFF_CTRL: begin
               en_d = bus.mem_write_val[0];
               ar_d = bus.mem_write_val[1];
               if (bus.mem_write_val[2]) mf_d = 1'b0;
            end
            OFF_COUNT: count_d = bus.mem_write_val;
            OFF_CMP:   cmp_d   = bus.mem_write_val;
            default: ;
         endcase
      end

      // A match in the same cycle wins over a write-1-to-clear.
      if (cmp_hit) mf_d = 1'b1;

      if (rd) begin
         rdata_d = rd_mux;
         hit_d   = 1'b1;
      end
   end

   // Register and timer state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q   <= '0;
         en_q    <= 1'b0;
         ar_q    <= 1'b0;
         mf_q    <= 1'b0;
         count_q <= '0;
         cmp_q   <= '1;
      end else begin
         led_q   <= led_d;
         en_q    <= en_d;
         ar_q    <= ar_d;
         mf_q    <= mf_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
      end
   end

   // Read data pipeline; hit lasts only for the cycle after a read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         hit_q   <= hit_d;
      end
   end

   assign bus.mem_read_val = rdata_q;
   assign bus.hit          = hit_q;
   assign led              = led_q;
   assign match            = mf_q;
endmodule

// File: tb/tb_mmio_timer_led.sv
// Bench for mmio_timer_led: directed scenarios plus random bus traffic,
// all checked cycle by cycle against a behavioural register model.
module tb_mmio_timer_led;
   localparam int BASE = 208;

   logic       clk;
   logic       reset;
   logic [3:0] led;
   logic       match;

   int n_vec;
   int n_err;

   mmio_timer_led_if #(.AW(8), .DW(32)) bus_if ();

   mmio_timer_led #(.MEM_WIDTH(32), .MEM_SIZE(256), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave),
      .led   (led),
      .match (match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state.
   logic [3:0]  m_led;
   logic        m_en, m_ar, m_mf;
   logic [31:0] m_count, m_cmp, m_rd;
   logic        m_hit;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_led = 4'h0; m_en = 1'b0; m_ar = 1'b0; m_mf = 1'b0;
      m_count = 32'h0; m_cmp = 32'hFFFF_FFFF; m_rd = 32'h0; m_hit = 1'b0;
   endtask

   // One rising edge as seen from the register map.
   task automatic model_step(input bit re, input bit we, input int addr, input logic [31:0] wval);
      bit          in_win;
      int          off;
      bit          hitm;
      logic [31:0] nxt;
      in_win = ((addr / 4) == (BASE / 4));
      off    = addr % 4;
      hitm   = m_en && (m_count == m_cmp);

      m_hit = 1'b0;
      m_rd  = 32'h0;
      if (re && in_win) begin
         m_hit = 1'b1;
         case (off)
            0: m_rd = {28'h0, m_led};
            1: m_rd = {29'h0, m_mf, m_ar, m_en};
            2: m_rd = m_count;
            default: m_rd = m_cmp;
         endcase
      end

      nxt = m_count;
      if (m_en) nxt = (hitm && m_ar) ? 32'h0 : m_count + 32'h1;

      if (we && in_win) begin
         case (off)
            0: m_led = wval[3:0];
            1: begin
               if (wval[2]) m_mf = 1'b0;
               m_en = wval[0];
               m_ar = wval[1];
            end
            2: nxt = wval;
            default: m_cmp = wval;
         endcase
      end
      if (hitm) m_mf = 1'b1;
      m_count = nxt;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".hit"},   {31'h0, bus_if.hit}, {31'h0, m_hit});
      chk({tag, ".rdata"}, bus_if.mem_read_val, m_rd);
      chk({tag, ".led"},   {28'h0, led},        {28'h0, m_led});
      chk({tag, ".match"}, {31'h0, match},      {31'h0, m_mf});
   endtask

   // Drive one bus cycle, advance the model at the edge, check after it.
   task automatic cycle(input string tag, input bit re, input bit we, input int addr, input logic [31:0] wval);
      bus_if.mem_read_en   = re;
      bus_if.mem_write_en  = we;
      bus_if.mem_addr      = addr[7:0];
      bus_if.mem_write_val = wval;
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step(re, we, addr, wval);
      #1;
      check_outputs(tag);
   endtask

   task automatic wr(input string tag, input int addr, input logic [31:0] v);
      cycle(tag, 1'b0, 1'b1, addr, v);
   endtask

   task automatic rd(input string tag, input int addr);
      cycle(tag, 1'b1, 1'b0, addr, 32'h0);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 1'b0, 0, 32'h0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      bus_if.mem_read_en   = 1'b0;
      bus_if.mem_write_en  = 1'b0;
      bus_if.mem_addr      = 8'h0;
      bus_if.mem_write_val = 32'h0;
      model_reset();

      // Random traffic while held in reset must have no effect.
      for (int i = 0; i < 8; i++)
         cycle("rst", 1'($urandom), 1'($urandom), BASE + int'($urandom_range(0, 3)), $urandom);
      reset = 1'b1;
      rd("rst_cmp", BASE + 3);
      chk("rst_cmp_val", bus_if.mem_read_val, 32'hFFFF_FFFF);

      // LED register.
      wr("led_wr", BASE, 32'h0000_00A5);
      chk("led_val", {28'h0, led}, 32'h5);
      rd("led_rd", BASE);
      chk("led_rd_val", bus_if.mem_read_val, 32'h5);
      idle("led_idle");
      chk("led_hit_drop", {31'h0, bus_if.hit}, 32'h0);

      // Decode: neighbours of the window are ignored.
      wr("led_clr", BASE, 32'h0);
      wr("dec_lo", BASE - 1, 32'h7);
      wr("dec_hi", BASE + 4, 32'h7);
      rd("dec_rd", BASE + 4);
      chk("dec_led", {28'h0, led}, 32'h0);
      chk("dec_hit", {31'h0, bus_if.hit}, 32'h0);

      // Single-shot compare.
      wr("ss_cmp", BASE + 3, 32'd5);
      wr("ss_cnt", BASE + 2, 32'd0);
      wr("ss_en",  BASE + 1, 32'h1);
      for (int i = 0; i < 6; i++) rd("ss_run", BASE + 2);
      chk("ss_match", {31'h0, match}, 32'h1);
      rd("ss_6", BASE + 2);
      chk("ss_6_val", bus_if.mem_read_val, 32'd6);
      rd("ss_7", BASE + 2);
      chk("ss_7_val", bus_if.mem_read_val, 32'd7);
      wr("ss_w1c", BASE + 1, 32'h5);
      chk("ss_cleared", {31'h0, match}, 32'h0);
      rd("ss_ctrl", BASE + 1);
      chk("ss_ctrl_val", bus_if.mem_read_val, 32'h1);

      // Auto-reload, with a W1C landing on the second match edge.
      wr("ar_stop", BASE + 1, 32'h4);
      wr("ar_cmp",  BASE + 3, 32'd3);
      wr("ar_cnt",  BASE + 2, 32'd0);
      wr("ar_en",   BASE + 1, 32'h3);
      for (int i = 0; i < 7; i++) rd("ar_seq", BASE + 2);
      wr("ar_w1c", BASE + 1, 32'h7);
      chk("ar_set_wins", {31'h0, match}, 32'h1);

      // Wrap through zero with CMP=0.
      wr("wr_stop", BASE + 1, 32'h4);
      wr("wr_cnt",  BASE + 2, 32'hFFFF_FFFE);
      wr("wr_cmp",  BASE + 3, 32'h0);
      wr("wr_en",   BASE + 1, 32'h1);
      rd("wr_a", BASE + 2);
      chk("wr_a_val", bus_if.mem_read_val, 32'hFFFF_FFFE);
      rd("wr_b", BASE + 2);
      chk("wr_b_val", bus_if.mem_read_val, 32'hFFFF_FFFF);
      chk("wr_nomf", {31'h0, match}, 32'h0);
      rd("wr_c", BASE + 2);
      chk("wr_zero_mf", {31'h0, match}, 32'h1);

      // Bus write to COUNT on a match edge.
      wr("pr_stop", BASE + 1, 32'h4);
      wr("pr_cnt",  BASE + 2, 32'd7);
      wr("pr_cmp",  BASE + 3, 32'd7);
      wr("pr_en",   BASE + 1, 32'h1);
      wr("pr_wr10", BASE + 2, 32'd10);
      chk("pr_mf", {31'h0, match}, 32'h1);
      rd("pr_rd", BASE + 2);
      chk("pr_cnt_val", bus_if.mem_read_val, 32'd10);

      // Randomized traffic, biased toward the window and small values.
      for (int i = 0; i < 3000; i++) begin
         int          a;
         logic [31:0] v;
         a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : BASE + int'($urandom_range(0, 3));
         v = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
         cycle("rnd", 1'($urandom), ($urandom_range(0, 2) == 0), a, v);
      end

      // Reset in the middle of a pending read.
      rd("mid_rd", BASE);
      chk("mid_hit_before", {31'h0, bus_if.hit}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("mid_hit_async", {31'h0, bus_if.hit}, 32'h0);
      chk("mid_rdata", bus_if.mem_read_val, 32'h0);
      chk("mid_led", {28'h0, led}, 32'h0);
      chk("mid_match", {31'h0, match}, 32'h0);
      reset = 1'b1;
      rd("post_cmp", BASE + 3);
      chk("post_cmp_val", bus_if.mem_read_val, 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mmio_timer_led.md
Name: mmio_timer_led

Overview:
- Memory-mapped peripheral that responds on the Core's memory bus (mem_addr / mem_read_en / mem_write_en / mem_write_val / mem_read_val), alongside the MemoryController.
- Decodes a 4-word address window and implements an LED register plus a free-running compare timer.
- Presents registered read data and a hit flag, so the top level can mux its read data against RAM data with the same one-cycle latency as RAM.

Parameters:
- MEM_WIDTH, 32, data word width in bits
- MEM_SIZE, 256, words in address space; address width is $clog2(MEM_SIZE)
- BASE_ADDR, 208, first word of the 4-word register window; must be a multiple of 4 and ≤ MEM_SIZE-4

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- mem_addr  input  $clog2(MEM_SIZE)  word address from Core
- mem_read_en  input  1  read strobe, one cycle per access
- mem_write_en  input  1  write strobe, one cycle per access
- mem_write_val  input  MEM_WIDTH  write data
- mem_read_val  output  MEM_WIDTH  registered read data
- hit  output  1  registered; 1 when mem_read_val is driven by this block
- led  output  4  LED register bits [3:0]
- match  output  1  sticky compare-match flag (CTRL[2])

Behaviour:
- Decode: sel = (mem_addr[high:2] == BASE_ADDR[high:2]); offset = mem_addr[1:0]. Accesses with sel=0 are ignored entirely.
- Register map by offset:
  - 0 LED: bits [3:0] R/W; upper bits read 0.
  - 1 CTRL:
    - bit0 EN: timer runs.
    - bit1 AR: auto-reload to 0 on match.
    - bit2 MF: match flag; write-1-to-clear, a written 0 leaves it unchanged.
    - Other bits read 0.
  - 2 COUNT: full-width R/W counter.
  - 3 CMP: full-width R/W compare value.
- Reset (reset=0, async): LED=0, CTRL=0, COUNT=0, CMP={MEM_WIDTH{1'b1}}, mem_read_val=0, hit=0. Outputs led=0, match=0. Assertion mid-operation aborts any pending read: hit=0 immediately.
- Write: at the rising edge with mem_write_en=1 and sel=1, the addressed register updates. The new value is visible on the next read.
- Read: at the rising edge with mem_read_en=1 and sel=1, mem_read_val is loaded with the addressed register's pre-edge value and hit is set to 1. Latency is 1 cycle.
- Read with sel=0, or mem_read_en=0: mem_read_val=0 and hit=0 at that edge. hit is never held past one cycle without a new read.
- Read and write in the same cycle to the window: the write is performed, and the read returns the pre-write value.
- Timer, per edge when EN=1:
  - If COUNT==CMP, MF is set to 1, and COUNT becomes 0 if AR=1, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - COUNT wraps from 2^MEM_WIDTH-1 to 0 with no flag unless CMP matches.
- EN=0: COUNT holds; MF is not set.
- Priority on COUNT: a bus write to COUNT overrides increment and reload in the same cycle. The match test still uses the pre-edge COUNT, so MF can set in that cycle.
- Priority on MF: a set from a match overrides a W1C clear in the same cycle, so MF stays 1.
- Writing CTRL with EN=1 takes effect for counting from the following edge. The write edge itself uses the old EN.
- match = MF; led = LED[3:0]. Both are combinational from registers, with no extra latency.

Test Plan:
- Reset: hold reset=0, drive random bus traffic -> mem_read_val=0, hit=0, led=0, match=0; reading CMP after release returns 0xFFFFFFFF.
- LED: write 0xA5 to BASE_ADDR -> led=4'h5 next cycle; read BASE_ADDR -> one cycle later mem_read_val=0x00000005, hit=1; next idle cycle hit=0.
- Decode: write 0x7 to 207 and to 212, read 212 -> led unchanged at 0, hit stays 0 throughout.
- Timer single-shot: CMP=5, COUNT=0, CTRL=0x1 -> match rises on the edge where COUNT==5. COUNT reads 6, then 7 (no reload). Write CTRL=0x5 -> match=0, EN stays 1.
- Auto-reload: CMP=3, CTRL=0x3 -> COUNT sequence 0,1,2,3,0,1,2,3…; MF set at first 3. W1C in the same cycle as a match -> MF remains 1.
- Priority/wrap: COUNT=0xFFFFFFFE, CMP=0, EN=1 -> COUNT goes to 0xFFFFFFFF, then 0, then MF sets at COUNT==0. Write COUNT=10 on a match edge -> COUNT=10 and MF=1. Assert reset mid-read -> hit drops to 0 asynchronously.
